uart_tx_arbiter: RTL and testbench

Shares one uart_tx instance between NUM_REQ byte producers using round-robin arbitration. It accepts one byte per valid/ack handshake and drives the transmitter's send/data_in. It then tracks busy through a full frame and enforces a baud-tick guard interval before starting the next frame. It sits between the requesting blocks and uart_tx; baud_tick comes from the same baud generator that feeds uart_tx.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_if.sv | 34 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | uart_pkg : shared widths and arbiter state encoding.  rev 1.0  |
// +----------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [1:0] ARB_IDLE      = 2'd0;
  localparam logic [1:0] ARB_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ARB_WAIT_DONE = 2'd2;
  localparam logic [1:0] ARB_GUARD     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = ARB_IDLE,
    ST_WAIT_BUSY = ARB_WAIT_BUSY,
    ST_WAIT_DONE = ARB_WAIT_DONE,
    ST_GUARD     = ARB_GUARD
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | uart_tx_arbiter_if : requester and uart_tx side bundle. rev 1.0|
// +----------------------------------------------------------------+
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic                           baud_tick;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*UART_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ack;
  logic [UART_DATA_W-1:0]         tx_data;
  logic                           tx_send;
  logic                           tx_busy;
  logic                           active;
  logic [IDX_W-1:0]               owner;
  logic                           timeout_err;

  modport master (
    output baud_tick, req_valid, req_data, tx_busy,
    input  req_ack, tx_data, tx_send, active, owner, timeout_err
  );

  modport slave (
    input  baud_tick, req_valid, req_data, tx_busy,
    output req_ack, tx_data, tx_send, active, owner, timeout_err
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rr_pick : first set request at or after ptr, wrapping. rev 1.0 |
// +----------------------------------------------------------------+
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               found
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[pos]) begin
        found     = 1'b1;
        grant_idx = pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | uart_tx_arbiter : round-robin sharing of one uart_tx.  rev 1.0 |
// +----------------------------------------------------------------+
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int STOP_GUARD   = 1,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(BUSY_TIMEOUT);
  localparam int GCNT_W = $clog2(STOP_GUARD + 2);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [GCNT_W-1:0] GUARD_LAST = GCNT_W'((STOP_GUARD > 0) ? STOP_GUARD - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_REQ - 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_send_q, tx_send_d;
  logic [NUM_REQ-1:0]     req_ack_q, req_ack_d;
  logic                   active_q, active_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GCNT_W-1:0]      gcnt_q, gcnt_d;

  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant_idx (pick_idx),
    .found     (pick_found)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    tx_data_d     = tx_data_q;
    tx_send_d     = 1'b0;
    req_ack_d     = '0;
    active_d      = active_q;
    timeout_err_d = 1'b0;
    cnt_d         = cnt_q;
    gcnt_d        = gcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (!bus.tx_busy && pick_found) begin
          tx_data_d = bus.req_data[int'(pick_idx) * UART_DATA_W +: UART_DATA_W];
          tx_send_d = 1'b1;
          req_ack_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          owner_d   = pick_idx;
          active_d  = 1'b1;
          rr_ptr_d  = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
          cnt_d     = '0;
          state_d   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // The byte was already acked, so a lost frame is reported, not retried.
          timeout_err_d = 1'b1;
          active_d      = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (STOP_GUARD == 0) begin
            active_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            gcnt_d  = '0;
            state_d = ST_GUARD;
          end
        end
      end
      ST_GUARD: begin
        if (bus.baud_tick) begin
          if (gcnt_q == GUARD_LAST) begin
            active_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            gcnt_d = gcnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      tx_data_q     <= '0;
      tx_send_q     <= 1'b0;
      req_ack_q     <= '0;
      active_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
      gcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      tx_data_q     <= tx_data_d;
      tx_send_q     <= tx_send_d;
      req_ack_q     <= req_ack_d;
      active_q      <= active_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
      gcnt_q        <= gcnt_d;
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_send     = tx_send_q;
  assign bus.req_ack     = req_ack_q;
  assign bus.active      = active_q;
  assign bus.owner       = owner_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_uart_tx_arbiter : two arbiters (guard 2 / guard 0) with a    |
// | uart_tx busy model and a grant scoreboard.            rev 1.0   |
// +----------------------------------------------------------------+
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N           = 4;
  localparam int BT          = 16;
  localparam int FRAME_TICKS = 10;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus_a ();
  uart_tx_arbiter_if #(.NUM_REQ(N)) bus_b ();

  uart_tx_arbiter #(.NUM_REQ(N), .STOP_GUARD(2), .BUSY_TIMEOUT(BT)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a.slave)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .STOP_GUARD(0), .BUSY_TIMEOUT(BT)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b.slave)
  );

  logic [N-1:0] pk_req;
  logic [1:0]   pk_ptr;
  logic [1:0]   pk_idx;
  logic         pk_found;

  rr_pick #(.NUM_REQ(N)) u_pick (
    .req       (pk_req),
    .ptr       (pk_ptr),
    .grant_idx (pk_idx),
    .found     (pk_found)
  );

  // stimulus-side state, per lane (0 = guard 2, 1 = guard 0)
  logic [N-1:0]   vld [2];
  logic [N*8-1:0] dat [2];
  logic [1:0]     model_en;
  logic [1:0]     force_busy;
  logic [1:0]     mbusy;
  int             tcnt [2];
  logic [1:0]     bdiv = 2'd0;
  logic           tick;
  int             cyc = 0;
  logic           rst_seen = 1'b1;

  logic [1:0]     snd, act, toe, busy;
  logic [N-1:0]   ack [2];
  logic [7:0]     txd [2];
  logic [1:0]     own [2];

  assign tick = (bdiv == 2'd3);

  assign bus_a.baud_tick = tick;
  assign bus_a.req_valid = vld[0];
  assign bus_a.req_data  = dat[0];
  assign bus_a.tx_busy   = mbusy[0] | force_busy[0];
  assign bus_b.baud_tick = tick;
  assign bus_b.req_valid = vld[1];
  assign bus_b.req_data  = dat[1];
  assign bus_b.tx_busy   = mbusy[1] | force_busy[1];

  assign snd    = {bus_b.tx_send, bus_a.tx_send};
  assign act    = {bus_b.active, bus_a.active};
  assign toe    = {bus_b.timeout_err, bus_a.timeout_err};
  assign busy   = {bus_b.tx_busy, bus_a.tx_busy};
  assign ack[0] = bus_a.req_ack;
  assign ack[1] = bus_b.req_ack;
  assign txd[0] = bus_a.tx_data;
  assign txd[1] = bus_b.tx_data;
  assign own[0] = bus_a.owner;
  assign own[1] = bus_b.owner;

  // uart_tx stand-in: busy rises the clk after send, falls after FRAME_TICKS ticks
  always @(posedge clk) begin
    bdiv     <= bdiv + 2'd1;
    cyc      <= cyc + 1;
    rst_seen <= !reset_n;
    for (int l = 0; l < 2; l++) begin
      if (!reset_n) begin
        mbusy[l] <= 1'b0;
        tcnt[l]  <= 0;
      end else if (!mbusy[l]) begin
        if (snd[l] && model_en[l]) begin
          mbusy[l] <= 1'b1;
          tcnt[l]  <= 0;
        end
      end else if (tick) begin
        if (tcnt[l] == FRAME_TICKS - 1) mbusy[l] <= 1'b0;
        else tcnt[l] <= tcnt[l] + 1;
      end
    end
  end

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q [2][$];
  int   sg [2] = '{2, 0};
  bit   busy_prev [2], act_prev [2], fall_pend [2], exact [2], exp_to [2];
  int   ticks [2], ready [2], last_send [2], exp_send [2], to_seen [2], sends [2];
  int   ptr_m [2];
  int   rem [2][N];
  int   sent [2][N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (m[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] mkdata(input int l, input int i, input int n);
    return 8'((l * 128) + (i * 32) + (n * 5) + 3);
  endfunction

  task automatic mon(input int l);
    exp_t e;
    if (rst_seen) begin
      fall_pend[l] = 1'b0;
      exp_send[l]  = 0;
    end else begin
      if (busy_prev[l] && !busy[l] && act[l]) begin
        fall_pend[l] = 1'b1;
        ticks[l]     = 0;
        ready[l]     = (sg[l] == 0) ? cyc : -1;
      end else if (fall_pend[l] && tick && ready[l] < 0) begin
        ticks[l]++;
        if (ticks[l] == sg[l]) ready[l] = cyc;
      end
      if (act_prev[l] && !act[l] && !toe[l]) begin
        chk($sformatf("release_cycle_l%0d", l), cyc, fall_pend[l] ? ready[l] + 1 : -999);
        fall_pend[l] = 1'b0;
        if (exact[l] && exp_q[l].size() > 0) exp_send[l] = cyc + 1;
      end
      if (snd[l] || ack[l] != '0) begin
        sends[l]++;
        last_send[l] = cyc;
        chk($sformatf("send_with_ack_l%0d", l), snd[l], 1);
        chk($sformatf("idle_before_send_l%0d", l), act_prev[l], 0);
        if (exp_q[l].size() == 0) begin
          chk($sformatf("unexpected_send_l%0d", l), exp_q[l].size(), 1);
        end else begin
          e = exp_q[l].pop_front();
          chk($sformatf("tx_data_l%0d", l), txd[l], e.data);
          chk($sformatf("owner_l%0d", l), own[l], e.idx);
          chk($sformatf("req_ack_l%0d", l), ack[l], 32'd1 << e.idx);
        end
      end
      if (exp_send[l] != 0 && exp_send[l] == cyc) begin
        chk($sformatf("back_to_back_send_l%0d", l), snd[l], 1);
        exp_send[l] = 0;
      end
      if (toe[l]) begin
        chk($sformatf("timeout_expected_l%0d", l), exp_to[l], 1);
        chk($sformatf("timeout_cycle_l%0d", l), cyc, last_send[l] + BT);
        exp_to[l] = 1'b0;
        to_seen[l]++;
      end
    end
    act_prev[l]  = act[l];
    busy_prev[l] = busy[l];
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) mon(l);
    end
  end

  // Arms requesters in mask with count bytes each and queues the expected grant order.
  task automatic arm(input int l, input logic [N-1:0] mask, input int count);
    logic [N-1:0] m = mask;
    int r [N];
    int sm [N];
    int total = 0;
    int g;
    for (int i = 0; i < N; i++) begin
      r[i]  = mask[i] ? count : 0;
      sm[i] = 0;
      total += r[i];
      if (mask[i]) begin
        rem[l][i]  = count;
        sent[l][i] = 0;
        dat[l][8*i +: 8] = mkdata(l, i, 0);
      end
    end
    for (int k = 0; k < total; k++) begin
      g = pick(m, ptr_m[l]);
      exp_q[l].push_back('{idx: g, data: mkdata(l, g, sm[g])});
      sm[g]++;
      r[g]--;
      if (r[g] == 0) m[g] = 1'b0;
      ptr_m[l] = (g + 1) % N;
    end
    vld[l] = vld[l] | mask;
  endtask

  // Plays the requesters: on each ack, present the next byte or drop valid.
  task automatic serve(input int na, input int nb, input int budget);
    int got [2] = '{0, 0};
    int n = 0;
    while ((got[0] < na || got[1] < nb) && n < budget) begin
      @(posedge clk); #1;
      n++;
      for (int l = 0; l < 2; l++) begin
        for (int i = 0; i < N; i++) begin
          if (ack[l][i]) begin
            got[l]++;
            rem[l][i]--;
            if (rem[l][i] <= 0) begin
              vld[l][i] = 1'b0;
            end else begin
              sent[l][i]++;
              dat[l][8*i +: 8] = mkdata(l, i, sent[l][i]);
            end
          end
        end
      end
    end
    chk("grants_lane_a", got[0], na);
    chk("grants_lane_b", got[1], nb);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((act[0] || act[1]) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_lane_a", act[0], 0);
    chk("idle_lane_b", act[1], 0);
    chk("queue_drained_a", exp_q[0].size(), 0);
    chk("queue_drained_b", exp_q[1].size(), 0);
  endtask

  task automatic check_reset_outputs();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("rst_tx_send_l%0d", l), snd[l], 0);
      chk($sformatf("rst_req_ack_l%0d", l), ack[l], 0);
      chk($sformatf("rst_tx_data_l%0d", l), txd[l], 0);
      chk($sformatf("rst_owner_l%0d", l), own[l], 0);
      chk($sformatf("rst_active_l%0d", l), act[l], 0);
      chk($sformatf("rst_timeout_l%0d", l), toe[l], 0);
    end
  endtask

  task automatic rst_pulse();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs();
    reset_n  = 1'b1;
    ptr_m[0] = 0;
    ptr_m[1] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;
    int e;
    vld[0] = '0; vld[1] = '0;
    dat[0] = '0; dat[1] = '0;
    model_en   = 2'b11;
    force_busy = 2'b00;
    ptr_m[0] = 0; ptr_m[1] = 0;
    pk_req = '0; pk_ptr = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();

    // rr_pick on its own, all masks and pointers
    for (int m = 0; m < 16; m++) begin
      for (int p = 0; p < N; p++) begin
        pk_req = 4'(m);
        pk_ptr = 2'(p);
        #1;
        e = pick(4'(m), p);
        chk("pick_found", pk_found, (e >= 0) ? 1 : 0);
        if (e >= 0) chk("pick_idx", pk_idx, e);
      end
    end

    @(posedge clk); #1;
    reset_n = 1'b1;

    // single requester 1, byte A5
    rem[0][1] = 1;
    dat[0][15:8] = 8'hA5;
    exp_q[0].push_back('{idx: 1, data: 8'hA5});
    ptr_m[0] = 2;
    vld[0] = 4'b0010;
    serve(1, 0, 50);
    chk("active_after_grant", act[0], 1);
    wait_idle(200);
    chk("owner_held_after_idle", own[0], 1);
    chk("single_send_count", sends[0], 1);

    // all four valid from reset, two bytes each; lane b one requester back to back
    rst_pulse();
    exact[0] = 1'b1;
    exact[1] = 1'b1;
    arb_all: begin
      arm(0, 4'b1111, 2);
      arm(1, 4'b0001, 3);
    end
    serve(8, 3, 2000);
    wait_idle(200);
    exact[0] = 1'b0;
    exact[1] = 1'b0;

    // tx_busy never rises: timeout, no retry, next request still served
    model_en[0] = 1'b0;
    exp_to[0] = 1'b1;
    arm(0, 4'b0100, 1);
    serve(1, 0, 50);
    n = 0;
    while (to_seen[0] == 0 && n < BT + 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_seen", to_seen[0], 1);
    chk("idle_after_timeout", act[0], 0);
    model_en[0] = 1'b1;
    arm(0, 4'b1000, 1);
    serve(1, 0, 50);
    wait_idle(200);

    // reset while the frame is in flight (WAIT_DONE)
    arm(0, 4'b0001, 1);
    serve(1, 0, 50);
    n = 0;
    while (!busy[0] && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_rose", busy[0], 1);
    repeat (5) @(posedge clk);
    rst_pulse();
    arm(0, 4'b1001, 1);
    serve(2, 0, 300);
    wait_idle(200);

    // tx_busy held high while idle blocks the grant until it falls
    force_busy[0] = 1'b1;
    arm(0, 4'b0100, 1);
    s0 = sends[0];
    repeat (20) @(posedge clk);
    #1;
    chk("no_send_while_busy", sends[0], s0);
    chk("no_ack_while_busy", ack[0], 0);
    force_busy[0] = 1'b0;
    @(posedge clk); #1;
    chk("send_on_first_low_edge", snd[0], 1);
    chk("ack_on_first_low_edge", ack[0], 4'b0100);
    vld[0] = '0;
    wait_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
